// File: rtl/uart_rx.sv
// 8-N-1 UART receiver: 2-flop line synchroniser, 16x oversampled start/data/stop
// recovery with 2-of-3 mid-bit majority, and a valid/ack holding register.
//
// state     | meaning
// IDLE      | line idle, waiting for a tick that sees rx_sync low
// START     | validating the start bit, false start returns to IDLE
// DATA      | shifting in DATA_BITS data bits, LSB first
// STOP      | sampling the stop bit, early exit at the decision tick
// WAIT_IDLE | framing error seen, waiting for the line to return high
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk_50mhz,
  input  logic                 rst_n,
  input  logic                 rx_sample_tick,
  input  logic                 rx_in,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam int M  = OVERSAMPLE / 2;

  localparam logic [TW-1:0] IDX_A    = TW'(M - 1);
  localparam logic [TW-1:0] IDX_B    = TW'(M);
  localparam logic [TW-1:0] IDX_C    = TW'(M + 1);
  localparam logic [TW-1:0] IDX_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_s1_q, rx_s1_d;
  logic                 rx_sync_q, rx_sync_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 samp_a_q, samp_a_d;
  logic                 samp_b_q, samp_b_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_frame_err_q, rx_frame_err_d;
  logic                 rx_overrun_q, rx_overrun_d;

  logic                 in_bit;
  logic                 samp_en_a;
  logic                 samp_en_b;
  logic                 decide;
  logic                 bit_end;
  logic                 majority;

  always_ff @(posedge clk_50mhz) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (rx_sample_tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_sync_q) state_d = S_START;
        end
        S_START: begin
          if (decide && majority) state_d = S_IDLE;
          else if (bit_end)       state_d = S_DATA;
        end
        S_DATA: begin
          if (bit_end && (bit_cnt_q == BIT_LAST)) state_d = S_STOP;
        end
        S_STOP: begin
          if (decide) state_d = majority ? S_IDLE : S_WAIT_IDLE;
        end
        S_WAIT_IDLE: begin
          if (rx_sync_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Third sample is rx_sync itself at the decision tick, so no third flop is needed.
  always_comb begin
    in_bit    = rx_sample_tick &&
                ((state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP));
    samp_en_a = in_bit && (tick_cnt_q == IDX_A);
    samp_en_b = in_bit && (tick_cnt_q == IDX_B);
    decide    = in_bit && (tick_cnt_q == IDX_C);
    bit_end   = in_bit && (tick_cnt_q == IDX_LAST);
    majority  = (samp_a_q & samp_b_q) | (samp_a_q & rx_sync_q) | (samp_b_q & rx_sync_q);
    rx_busy   = (state_q != S_IDLE);
  end

  always_comb begin
    rx_s1_d        = rx_in;
    rx_sync_d      = rx_s1_q;
    tick_cnt_d     = tick_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    samp_a_d       = samp_a_q;
    samp_b_d       = samp_b_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = rx_valid_q & ~rx_ack;
    rx_frame_err_d = 1'b0;
    rx_overrun_d   = 1'b0;

    if (samp_en_a) samp_a_d = rx_sync_q;
    if (samp_en_b) samp_b_d = rx_sync_q;

    if (rx_sample_tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_sync_q) tick_cnt_d = TW'(1);
        end
        S_START: begin
          if (decide && majority) begin
            tick_cnt_d = '0;
          end else if (bit_end) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        S_DATA: begin
          if (decide) shift_d = {majority, shift_q[DATA_BITS-1:1]};
          if (bit_end) begin
            tick_cnt_d = '0;
            bit_cnt_d  = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BW'(1);
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        S_STOP: begin
          if (decide) begin
            tick_cnt_d = '0;
            rx_data_d  = shift_q;
            if (majority) begin
              rx_valid_d   = 1'b1;
              // A same-cycle ack consumes the old byte, so the new one is not an overrun.
              rx_overrun_d = rx_valid_q & ~rx_ack;
            end else begin
              rx_frame_err_d = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (!rst_n) begin
      rx_s1_q        <= 1'b1;
      rx_sync_q      <= 1'b1;
      tick_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      samp_a_q       <= 1'b0;
      samp_b_q       <= 1'b0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
      rx_overrun_q   <= 1'b0;
    end else begin
      rx_s1_q        <= rx_s1_d;
      rx_sync_q      <= rx_sync_d;
      tick_cnt_q     <= tick_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      samp_a_q       <= samp_a_d;
      samp_b_q       <= samp_b_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rx_frame_err_q <= rx_frame_err_d;
      rx_overrun_q   <= rx_overrun_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_frame_err_q;
  assign rx_overrun   = rx_overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven on the sample-tick grid so every
// sample index is known exactly and expected values are hand-derived.
module tb_uart_rx;

  localparam int TICK_DIV = 27;

  logic       clk_50mhz = 1'b0;
  logic       rst_n;
  logic       rx_sample_tick;
  logic       rx_in;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_busy;

  int n_cmp     = 0;
  int n_fail    = 0;
  int fe_cnt    = 0;
  int ov_cnt    = 0;
  int busy_cyc  = 0;
  int both_cnt  = 0;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk_50mhz      (clk_50mhz),
    .rst_n          (rst_n),
    .rx_sample_tick (rx_sample_tick),
    .rx_in          (rx_in),
    .rx_ack         (rx_ack),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_frame_err   (rx_frame_err),
    .rx_overrun     (rx_overrun),
    .rx_busy        (rx_busy)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  initial begin
    rx_sample_tick = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(posedge clk_50mhz);
      #1 rx_sample_tick = 1'b1;
      @(posedge clk_50mhz);
      #1 rx_sample_tick = 1'b0;
    end
  end

  always @(negedge clk_50mhz) begin
    if (rx_frame_err === 1'b1) fe_cnt++;
    if (rx_overrun === 1'b1) ov_cnt++;
    if (rx_busy === 1'b1) busy_cyc++;
    if (rx_frame_err === 1'b1 && rx_overrun === 1'b1) both_cnt++;
  end

  // Returns 1 time unit after the n-th sampled tick edge.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_50mhz);
      while (rx_sample_tick !== 1'b1) @(posedge clk_50mhz);
    end
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit glitch, input logic stop_val);
    rx_in = 1'b0;
    wait_ticks(16);
    for (int b = 0; b < 8; b++) begin
      rx_in = d[b];
      if (glitch) begin
        wait_ticks(8);
        rx_in = ~d[b];
        wait_ticks(1);
        rx_in = d[b];
        wait_ticks(7);
      end else begin
        wait_ticks(16);
      end
    end
    rx_in = stop_val;
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    @(posedge clk_50mhz);
    #1 rx_ack = 1'b0;
  endtask

  task automatic test_reset();
    rx_in  = 1'b1;
    rx_ack = 1'b0;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk_50mhz);
    #1;
    n_cmp++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", rx_data); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", rx_valid); end
    n_cmp++; if (rx_frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got %b want 0", rx_frame_err); end
    n_cmp++; if (rx_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr got %b want 0", rx_overrun); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", rx_busy); end
    rst_n = 1'b1;
    wait_ticks(3);
  endtask

  task automatic test_single_byte();
    int fe0 = fe_cnt;
    int ov0 = ov_cnt;
    send_frame(8'hA5, 1'b0, 1'b1);
    wait_ticks(9);
    n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL a5_early_valid got %b want 0", rx_valid); end
    wait_ticks(1);
    n_cmp++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL a5_valid got %b want 1", rx_valid); end
    n_cmp++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL a5_data got %h want a5", rx_data); end
    wait_ticks(6);
    n_cmp++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL a5_ferr_pulses got %0d want 0", fe_cnt - fe0); end
    n_cmp++; if (ov_cnt - ov0 !== 0) begin n_fail++; $display("FAIL a5_ovr_pulses got %0d want 0", ov_cnt - ov0); end
    pulse_ack();
    n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ack_clear got %b want 0", rx_valid); end
    pulse_ack();
    n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL idle_ack_valid got %b want 0", rx_valid); end
    n_cmp++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL idle_ack_data got %h want a5", rx_data); end
  endtask

  task automatic test_back_to_back();
    int ov0 = ov_cnt;
    send_frame(8'h00, 1'b0, 1'b1);
    wait_ticks(10);
    n_cmp++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL b2b_first_data got %h want 00", rx_data); end
    n_cmp++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first_valid got %b want 1", rx_valid); end
    wait_ticks(6);
    send_frame(8'hFF, 1'b0, 1'b1);
    wait_ticks(10);
    n_cmp++; if (rx_data !== 8'hFF) begin n_fail++; $display("FAIL b2b_second_data got %h want ff", rx_data); end
    n_cmp++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second_valid got %b want 1", rx_valid); end
    wait_ticks(6);
    n_cmp++; if (ov_cnt - ov0 !== 1) begin n_fail++; $display("FAIL b2b_ovr_cycles got %0d want 1", ov_cnt - ov0); end
  endtask

  task automatic test_ack_collision();
    int ov0 = ov_cnt;
    send_frame(8'h12, 1'b0, 1'b1);
    wait_ticks(9);
    // Raise ack for exactly the cycle whose edge samples the stop-bit decision tick.
    repeat (TICK_DIV - 1) @(posedge clk_50mhz);
    #1 rx_ack = 1'b1;
    @(posedge clk_50mhz);
    #1 rx_ack = 1'b0;
    n_cmp++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL coll_valid got %b want 1", rx_valid); end
    n_cmp++; if (rx_data !== 8'h12) begin n_fail++; $display("FAIL coll_data got %h want 12", rx_data); end
    wait_ticks(6);
    n_cmp++; if (ov_cnt - ov0 !== 0) begin n_fail++; $display("FAIL coll_ovr got %0d want 0", ov_cnt - ov0); end
  endtask

  task automatic test_false_start();
    int fe0 = fe_cnt;
    int b0  = busy_cyc;
    rx_in = 1'b0;
    wait_ticks(4);
    rx_in = 1'b1;
    wait_ticks(12);
    n_cmp++; if (busy_cyc - b0 !== 9 * TICK_DIV) begin n_fail++; $display("FAIL fs_busy_cycles got %0d want %0d", busy_cyc - b0, 9 * TICK_DIV); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL fs_busy got %b want 0", rx_busy); end
    n_cmp++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL fs_valid got %b want 1", rx_valid); end
    n_cmp++; if (rx_data !== 8'h12) begin n_fail++; $display("FAIL fs_data got %h want 12", rx_data); end
    n_cmp++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL fs_ferr got %0d want 0", fe_cnt - fe0); end
  endtask

  task automatic test_break();
    int fe0 = fe_cnt;
    int ov0 = ov_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    wait_ticks(10);
    n_cmp++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL brk_data got %h want 3c", rx_data); end
    n_cmp++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL brk_valid got %b want 1", rx_valid); end
    wait_ticks(630);
    n_cmp++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL brk_busy_low_line got %b want 1", rx_busy); end
    n_cmp++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL brk_ferr_count got %0d want 1", fe_cnt - fe0); end
    n_cmp++; if (ov_cnt - ov0 !== 0) begin n_fail++; $display("FAIL brk_ovr got %0d want 0", ov_cnt - ov0); end
    rx_in = 1'b1;
    wait_ticks(2);
    n_cmp++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL brk_release_busy got %b want 0", rx_busy); end
    pulse_ack();
    send_frame(8'h81, 1'b0, 1'b1);
    wait_ticks(10);
    n_cmp++; if (rx_data !== 8'h81) begin n_fail++; $display("FAIL brk_next_data got %h want 81", rx_data); end
    n_cmp++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL brk_next_valid got %b want 1", rx_valid); end
    wait_ticks(6);
    n_cmp++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL brk_ferr_after got %0d want 1", fe_cnt - fe0); end
    n_cmp++; if (ov_cnt - ov0 !== 0) begin n_fail++; $display("FAIL brk_next_ovr got %0d want 0", ov_cnt - ov0); end
  endtask

  task automatic test_glitch();
    pulse_ack();
    send_frame(8'h55, 1'b1, 1'b1);
    wait_ticks(10);
    n_cmp++; if (rx_data !== 8'h55) begin n_fail++; $display("FAIL glitch_data got %h want 55", rx_data); end
    n_cmp++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL glitch_valid got %b want 1", rx_valid); end
    wait_ticks(6);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    int fe0;
    int ov0;
    d = 8'h7E;
    rx_in = 1'b0;
    wait_ticks(16);
    for (int b = 0; b < 4; b++) begin
      rx_in = d[b];
      wait_ticks(16);
    end
    rx_in = d[4];
    wait_ticks(5);
    rst_n = 1'b0;
    @(posedge clk_50mhz);
    #1 rst_n = 1'b1;
    n_cmp++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL mid_rst_data got %h want 00", rx_data); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b want 0", rx_valid); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got %b want 0", rx_busy); end
    n_cmp++; if (rx_frame_err !== 1'b0 || rx_overrun !== 1'b0) begin n_fail++; $display("FAIL mid_rst_flags got %b%b want 00", rx_frame_err, rx_overrun); end
    rx_in = 1'b1;
    wait_ticks(20);
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    n_cmp++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_idle got %b want 0", rx_busy); end
    send_frame(8'h7E, 1'b0, 1'b1);
    wait_ticks(10);
    n_cmp++; if (rx_data !== 8'h7E) begin n_fail++; $display("FAIL mid_rst_next_data got %h want 7e", rx_data); end
    n_cmp++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL mid_rst_next_valid got %b want 1", rx_valid); end
    wait_ticks(6);
    n_cmp++; if (fe_cnt - fe0 !== 0 || ov_cnt - ov0 !== 0) begin n_fail++; $display("FAIL mid_rst_next_flags got %0d/%0d want 0/0", fe_cnt - fe0, ov_cnt - ov0); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_ack_collision();
    test_false_start();
    test_break();
    test_glitch();
    test_reset_mid_frame();
    n_cmp++; if (both_cnt !== 0) begin n_fail++; $display("FAIL ferr_ovr_overlap got %0d want 0", both_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
